// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute unit and the ALU control decoder.
// The op codes live here so both ends use the same encodings.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1101;
    localparam logic [3:0] OP_SRL = 4'b1110;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    // An unknown op compares false here, so it falls through to the
    // single-cycle path where it is flagged illegal.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between the sequencer (master) and the execute unit (slave).
interface alu_seq_exec_if
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);

    logic            start;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output start, alu_op, op_a, op_b,
        input  busy, done, result, zero, illegal
    );

    modport slave (
        input  start, alu_op, op_a, op_b,
        output busy, done, result, zero, illegal
    );

endinterface

// File: rtl/alu_seq_exec_alu_simple.sv
// Single-cycle combinational datapath: ADD/SUB/AND/OR/XOR/SLT, anything else flagged illegal.
module alu_simple
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] res,
    output logic            illegal
);

    always_comb begin
        res     = '0;
        illegal = 1'b0;
        case (alu_op)
            OP_ADD:  res = op_a + op_b;
            OP_SUB:  res = op_a - op_b;
            OP_AND:  res = op_a & op_b;
            OP_OR:   res = op_a | op_b;
            OP_XOR:  res = op_a ^ op_b;
            OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle execute unit: logic/arith ops complete in one cycle,
// shifts iterate one bit per cycle under a start/busy/done handshake.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_seq_exec_if.slave bus
);

    state_e              state_q, state_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]     sh_q, sh_d;
    logic [3:0]          sop_q, sop_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                zero_q, zero_d;
    logic                illegal_q, illegal_d;
    logic                done_q, done_d;

    logic [XLEN-1:0]     simple_res;
    logic                simple_ill;
    logic [SHAMT_W-1:0]  shamt;
    logic [XLEN-1:0]     sh_next;

    alu_simple #(
        .XLEN(XLEN)
    ) u_alu_simple (
        .alu_op  (bus.alu_op),
        .op_a    (bus.op_a),
        .op_b    (bus.op_b),
        .res     (simple_res),
        .illegal (simple_ill)
    );

    function automatic logic [XLEN-1:0] shift_one(input logic [XLEN-1:0] v,
                                                  input logic [3:0]      op);
        case (op)
            OP_SLL:  return {v[XLEN-2:0], 1'b0};
            OP_SRL:  return {1'b0, v[XLEN-1:1]};
            default: return {v[XLEN-1], v[XLEN-1:1]};
        endcase
    endfunction

    assign shamt   = bus.op_b[SHAMT_W-1:0];
    assign sh_next = shift_one(sh_q, sop_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        sop_d     = sop_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (is_shift_op(bus.alu_op)) begin
                        if (shamt == '0) begin
                            result_d  = bus.op_a;
                            zero_d    = (bus.op_a == '0);
                            illegal_d = 1'b0;
                            done_d    = 1'b1;
                        end else begin
                            state_d = SHIFT;
                            sh_d    = bus.op_a;
                            cnt_d   = shamt;
                            sop_d   = bus.alu_op;
                        end
                    end else begin
                        result_d  = simple_res;
                        zero_d    = (simple_res == '0);
                        illegal_d = simple_ill;
                        done_d    = 1'b1;
                    end
                end
            end

            SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - 1'b1;
                // Last step: write the shifted value straight to the result.
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d   = IDLE;
                    result_d  = sh_next;
                    zero_d    = (sh_next == '0);
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            sop_q     <= OP_SLL;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            sop_q     <= sop_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.zero    = zero_q;
    assign bus.illegal = illegal_q;

endmodule
